// File: rtl/tff_down_counter.sv
// Loadable down counter built as a borrow-driven toggle chain; serves as an
// interval/timeout timer with optional auto-reload and a one-cycle done pulse.
module tff_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             terminal;

  // Bit 0 always toggles; bit i toggles only when every lower bit is 0 (borrow).
  function automatic logic [WIDTH-1:0] tff_borrow_step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] toggle;
    logic             lower_zero;
    toggle     = '0;
    lower_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i]  = lower_zero;
      lower_zero = lower_zero & ~v[i];
    end
    return v ^ toggle;
  endfunction

  assign terminal = (count_q == WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      if (load_val != '0) begin
        count_d  = load_val;
        reload_d = load_val;
        state_d  = COUNT;
      end else begin
        // A zero interval completes immediately.
        count_d = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if ((state_q == COUNT) && en) begin
      if (terminal) begin
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else begin
        count_d = tff_borrow_step(count_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign q    = count_q;
  assign busy = (state_q == COUNT);
  assign done = done_q;

endmodule

// File: tb/tb_tff_down_counter.sv
// Scoreboard bench for tff_down_counter: a behavioural model queues the
// expected {q,busy,done} per edge, and each scenario task pops and compares.
module tb_tff_down_counter;

  typedef struct {
    logic [2:0] q;
    logic [2:0] rl;
    logic       busy;
    logic       done;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0, load = 1'b0, en = 1'b0, auto_reload = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] q3;
  logic       busy3, done3;

  logic       reset1 = 1'b0, load1 = 1'b0, en1 = 1'b0, ar1 = 1'b0;
  logic [0:0] lv1 = '0;
  logic [0:0] q1;
  logic       busy1, done1;

  int         vectors = 0;
  int         miscompares = 0;
  mdl_t       m3, m1;
  logic [4:0] exp3[$];
  logic [4:0] exp1[$];

  tff_down_counter #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .q(q3), .busy(busy3), .done(done3)
  );

  tff_down_counter #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset1), .load(load1), .load_val(lv1), .en(en1),
    .auto_reload(ar1), .q(q1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  function automatic mdl_t model_next(mdl_t s, logic rst, logic ld, logic [2:0] lv,
                                      logic e, logic ar, logic [2:0] mask);
    mdl_t n;
    n = s;
    n.done = 1'b0;
    if (rst) begin
      n.q = '0; n.rl = '0; n.busy = 1'b0;
    end else if (ld) begin
      if ((lv & mask) != 3'd0) begin
        n.q = lv & mask; n.rl = lv & mask; n.busy = 1'b1;
      end else begin
        n.q = '0; n.busy = 1'b0; n.done = 1'b1;
      end
    end else if (s.busy && e) begin
      if (s.q == 3'd1) begin
        n.done = 1'b1;
        if (ar) n.q = s.rl;
        else begin
          n.q = '0; n.busy = 1'b0;
        end
      end else begin
        n.q = (s.q - 3'd1) & mask;
      end
    end
    return n;
  endfunction

  task automatic drive3(input logic r, input logic ld, input logic [2:0] lv,
                        input logic e, input logic ar);
    reset = r; load = ld; load_val = lv; en = e; auto_reload = ar;
    m3 = model_next(m3, r, ld, lv, e, ar, 3'b111);
    exp3.push_back({m3.q, m3.busy, m3.done});
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic r, input logic ld, input logic lv,
                        input logic e, input logic ar);
    reset1 = r; load1 = ld; lv1 = lv; en1 = e; ar1 = ar;
    m1 = model_next(m1, r, ld, {2'b00, lv}, e, ar, 3'b001);
    exp1.push_back({m1.q, m1.busy, m1.done});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] e;
    for (int i = 0; i < 2; i++) begin
      drive3(1, 0, 3'd0, 1, 0);
      e = exp3.pop_front();
      vectors++;
      if ({q3, busy3, done3} !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got q,busy,done=%b required %b", i, {q3, busy3, done3}, e);
      end
      vectors++;
      if ({q3, busy3, done3} !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_const[%0d]: got %b required 00000", i, {q3, busy3, done3});
      end
    end
    drive3(0, 0, 3'd0, 0, 0);
    void'(exp3.pop_front());
  endtask

  task automatic test_one_shot;
    logic [4:0] e;
    int         seq[8] = '{5, 4, 3, 2, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive3(0, 1, 3'd5, 0, 0);
      else        drive3(0, 0, 3'd0, 1, 0);
      e = exp3.pop_front();
      vectors++;
      if ({q3, busy3, done3} !== e) begin
        miscompares++;
        $display("FAIL one_shot[%0d]: got %b required %b", i, {q3, busy3, done3}, e);
      end
      vectors++;
      if (q3 !== 3'(seq[i]) || done3 !== (i == 5) || busy3 !== (i < 5)) begin
        miscompares++;
        $display("FAIL one_shot_seq[%0d]: got q=%0d busy=%b done=%b required q=%0d busy=%b done=%b",
                 i, q3, busy3, done3, seq[i], (i < 5), (i == 5));
      end
    end
  endtask

  task automatic test_auto_reload;
    logic [4:0] e;
    drive3(0, 1, 3'd3, 0, 1);
    void'(exp3.pop_front());
    for (int i = 0; i < 9; i++) begin
      drive3(0, 0, 3'd0, 1, 1);
      e = exp3.pop_front();
      vectors++;
      if ({q3, busy3, done3} !== e) begin
        miscompares++;
        $display("FAIL auto_reload[%0d]: got %b required %b", i, {q3, busy3, done3}, e);
      end
      vectors++;
      if (done3 !== (i % 3 == 2) || busy3 !== 1'b1 || q3 == 3'd0) begin
        miscompares++;
        $display("FAIL auto_reload_period[%0d]: got q=%0d busy=%b done=%b", i, q3, busy3, done3);
      end
    end
  endtask

  task automatic test_en_toggle;
    logic [4:0] e;
    drive3(0, 1, 3'd7, 0, 0);
    void'(exp3.pop_front());
    for (int i = 0; i < 16; i++) begin
      drive3(0, 0, 3'd0, (i % 2 == 0), 0);
      e = exp3.pop_front();
      vectors++;
      if ({q3, busy3, done3} !== e) begin
        miscompares++;
        $display("FAIL en_toggle[%0d]: got %b required %b", i, {q3, busy3, done3}, e);
      end
    end
  endtask

  task automatic test_load_override;
    logic [4:0] e;
    drive3(0, 1, 3'd6, 0, 0);
    void'(exp3.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive3(0, 0, 3'd0, 1, 0);
      void'(exp3.pop_front());
    end
    // q is 1 here: a load on the terminal edge must win without a done pulse.
    drive3(0, 1, 3'd2, 1, 0);
    e = exp3.pop_front();
    vectors++;
    if ({q3, busy3, done3} !== e || {q3, busy3, done3} !== 5'b01010) begin
      miscompares++;
      $display("FAIL load_override: got %b required %b", {q3, busy3, done3}, e);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive3(0, 0, 3'd0, 1, 0);
      else        drive3(0, i != 3, 3'd0, 0, 0);
      e = exp3.pop_front();
      vectors++;
      if ({q3, busy3, done3} !== e) begin
        miscompares++;
        $display("FAIL zero_load[%0d]: got %b required %b", i, {q3, busy3, done3}, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] e;
    drive3(0, 1, 3'd6, 0, 0);
    drive3(0, 0, 3'd0, 1, 0);
    drive3(0, 0, 3'd0, 1, 0);
    repeat (3) void'(exp3.pop_front());
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive3(1, 0, 3'd0, 1, 0);
        1:       drive3(1, 1, 3'd5, 1, 0);
        default: drive3(0, 0, 3'd0, 1, 0);
      endcase
      e = exp3.pop_front();
      vectors++;
      if ({q3, busy3, done3} !== e || {q3, busy3, done3} !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got %b required %b", i, {q3, busy3, done3}, e);
      end
    end
  endtask

  task automatic test_width1;
    logic [4:0] e;
    drive1(1, 0, 1'b0, 0, 0);
    void'(exp1.pop_front());
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive1(0, 1, 1'b1, 0, 1);
      else if (i < 5)  drive1(0, 0, 1'b0, 1, 1);
      else             drive1(0, 0, 1'b0, 1, 0);
      e = exp1.pop_front();
      vectors++;
      if ({2'b00, q1, busy1, done1} !== e) begin
        miscompares++;
        $display("FAIL width1[%0d]: got %b required %b", i, {2'b00, q1, busy1, done1}, e);
      end
    end
    vectors++;
    if (q1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b1) begin
      miscompares++;
      $display("FAIL width1_oneshot_end: got q=%b busy=%b done=%b required 0 0 1", q1, busy1, done1);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_en_toggle();
    test_load_override();
    test_reset_mid();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
